// File: rtl/pwm_leg_ctrl_if.sv
// Shadow-configuration write bus for the PWM half-bridge leg controller.
// The master drives a one-cycle cfg_wr strobe together with the new settings.
interface pwm_leg_ctrl_if #(
    parameter int DT_W = 10
);
    logic            cfg_wr;
    logic [DT_W-1:0] cfg_dtime_a;
    logic [DT_W-1:0] cfg_dtime_b;
    logic            cfg_logic_a;
    logic            cfg_logic_b;
    logic            cfg_dt_en;

    modport master (
        output cfg_wr,
        output cfg_dtime_a,
        output cfg_dtime_b,
        output cfg_logic_a,
        output cfg_logic_b,
        output cfg_dt_en
    );

    modport slave (
        input cfg_wr,
        input cfg_dtime_a,
        input cfg_dtime_b,
        input cfg_logic_a,
        input cfg_logic_b,
        input cfg_dt_en
    );
endinterface

// File: rtl/pwm_leg_ctrl.sv
// Half-bridge leg sequencer: bootstrap precharge, arming, run, fault trip, shadowed dead-time config.
// Define PWM_LEG_FAULT_LATCH_EN to make TRIP sticky until fault_clr with fault low.
module pwm_leg_ctrl #(
    parameter int DT_W   = 10,
    parameter int BOOT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              fault,
    input  logic              fault_clr,
    input  logic              sync,
    input  logic [BOOT_W-1:0] boot_cycles,
    pwm_leg_ctrl_if.slave     cfg,
    output logic [DT_W-1:0]   dtime_a,
    output logic [DT_W-1:0]   dtime_b,
    output logic              logic_a,
    output logic              logic_b,
    output logic              dt_onoff,
    output logic              pwm_onoff,
    output logic              boot_low,
    output logic [2:0]        state,
    output logic              cfg_pending
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BOOT = 3'd1,
        ARM  = 3'd2,
        RUN  = 3'd3,
        TRIP = 3'd4
    } state_e;

    typedef struct packed {
        logic [DT_W-1:0] dta;
        logic [DT_W-1:0] dtb;
        logic            la;
        logic            lb;
        logic            en;
    } cfg_t;

    localparam cfg_t RST_CFG = '{
        dta: '0,
        dtb: '0,
        la:  1'b1,
        lb:  1'b1,
        en:  1'b1
    };

    state_e            state_q, state_d;
    logic [BOOT_W-1:0] cnt_q, cnt_d;
    cfg_t              shadow_q, shadow_d;
    cfg_t              active_q, active_d;
    logic              pend_q, pend_d;
    logic              wr_q, wr_d;

    cfg_t new_cfg;
    logic run_like;
    logic idle_like;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fault) begin
                    state_d = TRIP;
                end else if (start) begin
                    state_d = (boot_cycles != '0) ? BOOT : ARM;
                end
            end
            BOOT: begin
                if (fault) begin
                    state_d = TRIP;
                end else if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == boot_cycles - BOOT_W'(1)) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (fault) begin
                    state_d = TRIP;
                end else if (stop) begin
                    state_d = IDLE;
                end else if (sync) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fault) begin
                    state_d = TRIP;
                end else if (stop) begin
                    state_d = IDLE;
                end
            end
            TRIP: begin
`ifdef PWM_LEG_FAULT_LATCH_EN
                if (fault_clr && !fault) begin
                    state_d = IDLE;
                end
`else
                if (!fault) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts from zero every time BOOT is entered.
    always_comb begin
        cnt_d = '0;
        if (state_q == BOOT && state_d == BOOT) begin
            cnt_d = cnt_q + BOOT_W'(1);
        end
    end

    always_comb begin
        new_cfg = '{
            dta: cfg.cfg_dtime_a,
            dtb: cfg.cfg_dtime_b,
            la:  cfg.cfg_logic_a,
            lb:  cfg.cfg_logic_b,
            en:  cfg.cfg_dt_en
        };
        run_like  = (state_q == ARM) || (state_q == RUN);
        idle_like = (state_q == IDLE) || (state_q == TRIP);
        wr_d      = cfg.cfg_wr;
        shadow_d  = cfg.cfg_wr ? new_cfg : shadow_q;
        active_d  = active_q;
        pend_d    = pend_q;
        // A write landing on the carrier-zero strobe bypasses the shadow.
        if (cfg.cfg_wr && sync && run_like) begin
            active_d = new_cfg;
            pend_d   = 1'b0;
        end else begin
            if (pend_q && (sync || (wr_q && idle_like))) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
            end
            if (cfg.cfg_wr) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= RST_CFG;
            active_q <= RST_CFG;
            pend_q   <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            wr_q     <= wr_d;
        end
    end

    // Fault gates the enable combinationally, ahead of the TRIP transition.
    assign pwm_onoff   = (state_q == RUN) && !fault;
    assign boot_low    = (state_q == BOOT);
    assign state       = state_q;
    assign cfg_pending = pend_q;
    assign dtime_a     = active_q.dta;
    assign dtime_b     = active_q.dtb;
    assign logic_a     = active_q.la;
    assign logic_b     = active_q.lb;
    assign dt_onoff    = active_q.en;

endmodule

// File: tb/tb_pwm_leg_ctrl.sv
// Self-checking bench for pwm_leg_ctrl: directed scenarios then random traffic
// compared every cycle against a behavioural model of the leg.
module tb_pwm_leg_ctrl;

    localparam int DT_W   = 10;
    localparam int BOOT_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              fault;
    logic              fault_clr;
    logic              sync;
    logic [BOOT_W-1:0] boot_cycles;
    logic [DT_W-1:0]   dtime_a;
    logic [DT_W-1:0]   dtime_b;
    logic              logic_a;
    logic              logic_b;
    logic              dt_onoff;
    logic              pwm_onoff;
    logic              boot_low;
    logic [2:0]        state;
    logic              cfg_pending;

    pwm_leg_ctrl_if #(.DT_W(DT_W)) cfg_if ();

    pwm_leg_ctrl #(
        .DT_W   (DT_W),
        .BOOT_W (BOOT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .fault       (fault),
        .fault_clr   (fault_clr),
        .sync        (sync),
        .boot_cycles (boot_cycles),
        .cfg         (cfg_if.slave),
        .dtime_a     (dtime_a),
        .dtime_b     (dtime_b),
        .logic_a     (logic_a),
        .logic_b     (logic_b),
        .dt_onoff    (dt_onoff),
        .pwm_onoff   (pwm_onoff),
        .boot_low    (boot_low),
        .state       (state),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int boot_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [DT_W-1:0] a;
        logic [DT_W-1:0] b;
        logic            la;
        logic            lb;
        logic            en;
    } mcfg_t;

    int    m_st;
    int    m_left;
    mcfg_t m_sha;
    mcfg_t m_act;
    bit    m_pend;
    bit    m_wr_prev;

    task automatic model_reset();
        m_st      = 0;
        m_left    = 0;
        m_sha     = '{a: '0, b: '0, la: 1'b1, lb: 1'b1, en: 1'b1};
        m_act     = m_sha;
        m_pend    = 0;
        m_wr_prev = 0;
    endtask

    task automatic model_step();
        int    nst;
        mcfg_t inc;
        bit    run_like;
        bit    idle_like;
        nst = m_st;
        inc = '{a: cfg_if.cfg_dtime_a, b: cfg_if.cfg_dtime_b,
                la: cfg_if.cfg_logic_a, lb: cfg_if.cfg_logic_b,
                en: cfg_if.cfg_dt_en};
        run_like  = (m_st == 2) || (m_st == 3);
        idle_like = (m_st == 0) || (m_st == 4);
        if (m_st != 4 && fault) begin
            nst = 4;
        end else begin
            case (m_st)
                0: if (start) begin
                    if (boot_cycles == 0) nst = 2;
                    else begin
                        nst    = 1;
                        m_left = int'(boot_cycles);
                    end
                end
                1: if (stop) nst = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) nst = 2;
                   end
                2: if (stop) nst = 0;
                   else if (sync) nst = 3;
                3: if (stop) nst = 0;
                4: begin
`ifdef PWM_LEG_FAULT_LATCH_EN
                    if (fault_clr && !fault) nst = 0;
`else
                    if (!fault) nst = 0;
`endif
                end
                default: nst = 0;
            endcase
        end
        if (cfg_if.cfg_wr && sync && run_like) begin
            m_act  = inc;
            m_pend = 0;
        end else begin
            if (m_pend && (sync || (m_wr_prev && idle_like))) begin
                m_act  = m_sha;
                m_pend = 0;
            end
            if (cfg_if.cfg_wr) m_pend = 1;
        end
        if (cfg_if.cfg_wr) m_sha = inc;
        m_wr_prev = cfg_if.cfg_wr;
        m_st      = nst;
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_st));
        chk("pwm_onoff", 32'(pwm_onoff), 32'(m_st == 3 && !fault));
        chk("boot_low", 32'(boot_low), 32'(m_st == 1));
        chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
        chk("dtime_a", 32'(dtime_a), 32'(m_act.a));
        chk("dtime_b", 32'(dtime_b), 32'(m_act.b));
        chk("logic_a", 32'(logic_a), 32'(m_act.la));
        chk("logic_b", 32'(logic_b), 32'(m_act.lb));
        chk("dt_onoff", 32'(dt_onoff), 32'(m_act.en));
        if (boot_low) boot_seen++;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit st, input bit sp, input bit f,
                         input bit fc, input bit sy, input bit wr);
        start         = st;
        stop          = sp;
        fault         = f;
        fault_clr     = fc;
        sync          = sy;
        cfg_if.cfg_wr = wr;
        cyc();
    endtask

    task automatic set_cfg(input logic [DT_W-1:0] a, input logic [DT_W-1:0] b,
                           input logic la, input logic lb, input logic en);
        cfg_if.cfg_dtime_a = a;
        cfg_if.cfg_dtime_b = b;
        cfg_if.cfg_logic_a = la;
        cfg_if.cfg_logic_b = lb;
        cfg_if.cfg_dt_en   = en;
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_pwm", 32'(pwm_onoff), 32'(0));
        chk("rst_state", 32'(state), 32'(0));
        chk("rst_dtime_a", 32'(dtime_a), 32'(0));
        chk("rst_logic_a", 32'(logic_a), 32'(1));
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        fault         = 1'b0;
        fault_clr     = 1'b0;
        sync          = 1'b0;
        boot_cycles   = '0;
        cfg_if.cfg_wr = 1'b0;
        set_cfg('0, '0, 1'b1, 1'b1, 1'b1);
        model_reset();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1 reset = 1'b1;

        // Precharge of exactly five cycles, then arm and run on sync.
        boot_cycles = 16'd5;
        boot_seen   = 0;
        drive(1, 0, 0, 0, 0, 0);
        repeat (7) drive(0, 0, 0, 0, 0, 0);
        chk("boot_len", 32'(boot_seen), 32'(5));
        chk("armed", 32'(state), 32'(2));
        drive(0, 0, 0, 0, 1, 0);
        chk("pwm_after_sync", 32'(pwm_onoff), 32'(1));

        // Mid-carrier write stays pending until the next sync.
        set_cfg(10'd200, '0, 1'b1, 1'b1, 1'b1);
        drive(0, 0, 0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        chk("hold_dtime_a", 32'(dtime_a), 32'(0));
        chk("hold_pending", 32'(cfg_pending), 32'(1));
        drive(0, 0, 0, 0, 1, 0);
        chk("apply_dtime_a", 32'(dtime_a), 32'(200));
        chk("apply_pending", 32'(cfg_pending), 32'(0));

        // Write coincident with sync applies directly.
        set_cfg(10'd200, 10'd50, 1'b1, 1'b1, 1'b1);
        drive(0, 0, 0, 0, 1, 1);
        chk("direct_dtime_b", 32'(dtime_b), 32'(50));
        chk("direct_pending", 32'(cfg_pending), 32'(0));

        // Fault kills the enable in the same cycle, trips on the next edge.
        fault = 1'b1;
        #1;
        chk("fault_pwm_now", 32'(pwm_onoff), 32'(0));
        cyc();
        chk("trip_state", 32'(state), 32'(4));
        drive(0, 0, 0, 1, 0, 0);
        chk("trip_exit", 32'(state), 32'(0));

        // Zero precharge goes straight to ARM; fault wins over stop/start.
        boot_cycles = '0;
        drive(1, 0, 0, 0, 0, 0);
        chk("skip_boot", 32'(state), 32'(2));
        drive(0, 1, 0, 0, 0, 0);
        chk("arm_stop", 32'(state), 32'(0));
        boot_cycles = 16'd3;
        drive(1, 0, 0, 0, 0, 0);
        chk("in_boot", 32'(state), 32'(1));
        drive(1, 1, 1, 0, 0, 0);
        chk("fault_prio", 32'(state), 32'(4));
        drive(0, 0, 0, 1, 0, 0);

        // Asynchronous reset while running.
        boot_cycles = 16'd2;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("run_before_rst", 32'(state), 32'(3));
        async_reset_pulse();
        drive(0, 0, 0, 0, 1, 0);
        chk("no_restart", 32'(state), 32'(0));

        for (int i = 0; i < 3000; i++) begin
            if (m_st == 0 && $urandom_range(0, 3) == 0)
                boot_cycles = BOOT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0)
                set_cfg(DT_W'($urandom), DT_W'($urandom), 1'($urandom),
                        1'($urandom), 1'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                async_reset_pulse();
            end else begin
                drive($urandom_range(0, 99) < 20,
                      $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 15);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
